// File: rtl/data_mem_slave_pkg.sv
// Shared encodings and request record for the data-memory responder.
package data_mem_slave_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_X = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_BUSY = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

  localparam int MEM_WAIT_MAX = 15;

  // Request fields captured on the accept edge.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    mem_size_e   size;
    logic        uns;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load extract/extend.
module mem_lane_align
  import data_mem_slave_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic        misalign,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Store side: replicate the data onto every lane, enables pick the lanes.
  always_comb begin
    be       = 4'b0000;
    wword    = '0;
    misalign = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      MEM_SIZE_W: begin
        be       = 4'b1111;
        wword    = wdata;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // Load side: extract the selected lane(s) and extend; words pass through.
  always_comb begin
    rdata = rword;
    case (size)
      MEM_SIZE_B: rdata = uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      MEM_SIZE_H: rdata = uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default:    rdata = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_slave.sv
// Load/store responder: req/gnt accept, programmable wait states, one-cycle response.
module data_mem_slave
  import data_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q;
  mem_req_t              req_q;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] widx;
  logic                  oor;
  logic                  acc_err;
  logic                  access;
  logic [3:0]            be;
  logic [31:0]           wword;
  logic                  misalign;
  logic [31:0]           ld_data;

  assign widx    = req_q.addr[ADDR_WIDTH+1:2];
  assign oor     = (req_q.addr >> (ADDR_WIDTH + 2)) != '0;
  assign acc_err = oor || misalign || (req_q.size == MEM_SIZE_X);
  assign access  = (state_q == DMEM_BUSY) && (cnt_q == 4'd0);

  mem_lane_align u_align (
    .addr_lo  (req_q.addr[1:0]),
    .size     (req_q.size),
    .uns      (req_q.uns),
    .wdata    (req_q.wdata),
    .rword    (mem[widx]),
    .be       (be),
    .wword    (wword),
    .misalign (misalign),
    .rdata    (ld_data)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        gnt_o = 1'b1;
        if (req_i) state_d = DMEM_BUSY;
      end
      DMEM_BUSY: if (cnt_q == 4'd0) state_d = DMEM_RESP;
      DMEM_RESP: begin
        rvalid_o = 1'b1;
        state_d  = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // State, wait counter and response registers; response clears on leaving RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DMEM_IDLE: if (req_i) cnt_q <= 4'(WAIT_STATES);
        DMEM_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= (acc_err || req_q.we) ? 32'd0 : ld_data;
            err_q   <= acc_err;
          end
        end
        default: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Request latch; only the accept edge samples the inputs.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DMEM_IDLE && req_i) begin
      req_q.we    <= we_i;
      req_q.addr  <= addr_i;
      req_q.size  <= mem_size_e'(size_i);
      req_q.uns   <= unsigned_i;
      req_q.wdata <= wdata_i;
    end
  end

  // Array write with byte-lane enables; reset on the access edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && access && req_q.we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Randomized bench for data_mem_slave against a byte-addressed reference memory.
module tb_data_mem_slave;

  localparam int AW = 10;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, unsigned_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] ref_mem [0:4095];

  data_mem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, n = 2**size bytes little-endian.
  task automatic model(input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] exp_d, output logic exp_e);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    exp_e = (sz == 2'd3) || (a % n != 0) || ((a / 4) >= (32'd1 << AW));
    exp_d = 32'd0;
    if (exp_e) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[(a + i) % 4096] = 8'(wd >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 4096]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      exp_d = v;
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, output logic [31:0] rd);
    int cyc;
    logic [31:0] exp_d;
    logic exp_e;
    model(we, a, sz, uns, wd, exp_d, exp_e);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; size_i = sz; unsigned_i = uns; wdata_i = wd;
    cyc = 0;
    while (!gnt_o && cyc < 64) begin @(negedge clk); cyc++; end
    check("gnt_timeout", 32'(cyc < 64), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Inputs change after accept; the DUT must ignore them.
    req_i = 1'($urandom); we_i = 1'($urandom); addr_i = $urandom;
    size_i = 2'($urandom); unsigned_i = 1'($urandom); wdata_i = $urandom;
    check("gnt_busy", 32'(gnt_o), 32'd0);
    cyc = 0;
    while (!rvalid_o && cyc < 64) begin @(negedge clk); cyc++; end
    req_i = 1'b0;
    rd = rdata_o;
    check("latency", 32'(cyc), 32'(WS + 1));
    check("rdata", rdata_o, exp_d);
    check("err", 32'(err_o), 32'(exp_e));
    @(negedge clk);
    check("rvalid_1cyc", 32'(rvalid_o), 32'd0);
    check("rdata_idle", rdata_o | 32'(err_o), 32'd0);
  endtask

  // Store abandoned by a reset pulse sampled k edges after accept.
  task automatic rst_mid(input int k);
    int seen;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; size_i = 2'd2; unsigned_i = 1'b0;
    wdata_i = 32'h2222_2222;
    while (!gnt_o) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    seen = 0;
    for (int i = 0; i < k; i++) begin seen |= 32'(rvalid_o); @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WS + 4; i++) begin seen |= 32'(rvalid_o); @(negedge clk); end
    check("rst_no_rvalid", 32'(seen), 32'd0);
    check("rst_gnt", 32'(gnt_o), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [31:0] exp_d;
    logic exp_e;
    int acc[$];
    int rv[$];
    int nwin, r;

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; size_i = '0;
    unsigned_i = 1'b0; wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;

    // Prefill the working window and the top word.
    for (int i = 0; i < 16; i++) txn(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, rd);
    txn(1'b1, 32'hFFC, 2'd2, 1'b0, 32'hCAFE_F00D, rd);

    // Directed loads/stores.
    txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, rd);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd);  check("lw_10", rd, 32'hDEAD_BEEF);
    txn(1'b1, 32'h13, 2'd0, 1'b0, 32'h80, rd);
    txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, rd);  check("lb_13", rd, 32'hFFFF_FF80);
    txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, rd);  check("lbu_13", rd, 32'h0000_0080);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd);  check("lw_10b", rd, 32'h80AD_BEEF);
    txn(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, rd);  check("lhu_12", rd, 32'h0000_80AD);
    txn(1'b1, 32'h11, 2'd1, 1'b0, 32'h1234, rd);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd);  check("lw_10c", rd, 32'h80AD_BEEF);
    txn(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, rd);
    txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, rd);
    txn(1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0, rd); check("lw_ffc", rd, 32'hCAFE_F00D);

    // Back-to-back accepts with req held high.
    model(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, exp_d, exp_e);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; size_i = 2'd2; unsigned_i = 1'b0;
    for (int i = 0; i < 4 * (WS + 3) + 2; i++) begin
      if (gnt_o) acc.push_back(i);
      if (rvalid_o) begin rv.push_back(i); check("hold_rdata", rdata_o, exp_d); end
      @(negedge clk);
    end
    req_i = 1'b0;
    repeat (WS + 4) @(negedge clk);
    nwin = 0;
    foreach (acc[k]) if (acc[k] + WS + 2 < 4 * (WS + 3) + 2) nwin++;
    check("hold_nacc", 32'(acc.size()), 32'd5);
    check("hold_nrv", 32'(rv.size()), 32'(nwin));
    for (int k = 1; k < acc.size(); k++) check("hold_spacing", 32'(acc[k] - acc[k-1]), 32'(WS + 3));
    for (int k = 0; k < rv.size(); k++) check("hold_rv_lat", 32'(rv[k] - acc[k]), 32'(WS + 2));

    // Reset abandons an in-flight store, including on the access edge itself.
    txn(1'b1, 32'h20, 2'd2, 1'b0, 32'h1111_1111, rd);
    rst_mid(0);
    rst_mid(WS);
    txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd);  check("lw_20", rd, 32'h1111_1111);

    // Random mix of legal, misaligned, illegal-size and out-of-range accesses.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'hFFC + 32'($urandom_range(0, 3));
      else             a = $urandom | 32'h1000;
      txn(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
